imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface that the cpu fetch stage reads.

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_loader_if.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 37 +++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and the loader state encoding for the imem loader.
// The checksum stage is built only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;
   localparam int WIDTH = 32;
   localparam int BYTES = WIDTH / 8;

   typedef enum logic [2:0] {
      S_HDR  = 3'd0,
      S_DATA = 3'd1,
      S_CSUM = 3'd2,
      S_RUN  = 3'd3,
      S_ERR  = 3'd4
   } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in and imem write port out of the loader.
// The slave side is the loader; the master side is the stream source / memory model.
interface imem_loader_if #(parameter int ADDR_WIDTH = 8);
   import imem_loader_pkg::*;
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_waddr;
   logic [WIDTH-1:0]      imem_wdata;

   modport master (output in_data, in_valid,
                   input  in_ready, imem_we, imem_waddr, imem_wdata);
   modport slave  (input  in_data, in_valid,
                   output in_ready, imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8->32 assembler; word_valid marks the cycle the 4th byte is taken,
// with the full word presented combinationally alongside it.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             byte_en,
   input  logic [7:0]       byte_in,
   output logic [WIDTH-1:0] word,
   output logic             word_valid
);
   logic [1:0]       idx;
   logic [WIDTH-9:0] acc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx   <= 2'd0;
         acc_q <= '0;
      end else if (clear) begin
         idx   <= 2'd0;
         acc_q <= '0;
      end else if (byte_en) begin
         idx <= idx + 2'd1;
         case (idx)
            2'd0:    acc_q[7:0]   <= byte_in;
            2'd1:    acc_q[15:8]  <= byte_in;
            2'd2:    acc_q[23:16] <= byte_in;
            default: ;
         endcase
      end
   end

   assign word       = {byte_in, acc_q};
   assign word_valid = byte_en && (idx == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory, holding the core in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_req,
   imem_loader_if.slave bus,
   output logic         core_rst,
   output logic         done,
   output logic         error
);
   localparam logic [WIDTH-1:0]      ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]      CAPACITY = ONE << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = S_CSUM;
`else
   localparam state_t AFTER_DATA = S_RUN;
`endif

   state_t                state;
   logic [WIDTH-1:0]      nwords;
   logic [ADDR_WIDTH:0]   wcnt;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [WIDTH-1:0]      wdata_q;
   logic                  accept, word_valid, last_word;
   logic [WIDTH-1:0]      word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WIDTH-1:0]      csum_q;
`endif

   // A restart request blocks the byte so it can't leak into the new image.
   assign bus.in_ready = (state == S_HDR || state == S_DATA || state == S_CSUM) && !load_req;
   assign accept       = bus.in_valid && bus.in_ready;
   assign last_word    = ({{(WIDTH-ADDR_WIDTH-1){1'b0}}, wcnt} == nwords - ONE);

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (load_req),
      .byte_en    (accept),
      .byte_in    (bus.in_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_HDR;
         nwords   <= '0;
         wcnt     <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         core_rst <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         we_q     <= 1'b0;
         // Lags the state by one cycle so the final write lands before release.
         done     <= (state == S_RUN);
         core_rst <= (state != S_RUN);
         if (load_req) begin
            state    <= S_HDR;
            nwords   <= '0;
            wcnt     <= '0;
            waddr_q  <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
         end else begin
            case (state)
               S_HDR: if (word_valid) begin
                  nwords  <= word;
                  wcnt    <= '0;
                  waddr_q <= '0;
                  if (word > CAPACITY) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else if (word == '0) begin
                     state <= AFTER_DATA;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: if (word_valid) begin
                  we_q    <= 1'b1;
                  waddr_q <= wcnt[ADDR_WIDTH-1:0];
                  wdata_q <= word;
                  wcnt    <= wcnt + CNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q  <= csum_q ^ word;
`endif
                  if (last_word) state <= AFTER_DATA;
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               S_CSUM: if (word_valid) begin
                  if (word == csum_q) begin
                     state <= S_RUN;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
`endif
               S_RUN: ;
               S_ERR: error <= 1'b1;
               default: state <= S_HDR;
            endcase
         end
      end
   end

   assign bus.imem_we    = we_q;
   assign bus.imem_waddr = waddr_q;
   assign bus.imem_wdata = wdata_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN to append checksum words.
module tb_imem_loader;
   import imem_loader_pkg::*;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic load_req = 1'b0;
   logic core_rst, done, error;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .load_req (load_req),
      .bus      (bus),
      .core_rst (core_rst),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = 0;
   int done_cyc = -1;
   int we_while_run = 0;
   logic prev_done = 1'b0;
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_addr.push_back(bus.imem_waddr);
         wr_data.push_back(bus.imem_wdata);
         if (core_rst !== 1'b1) we_while_run++;
      end
      if (done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
      prev_done = done;
   end

   typedef struct {
      logic [31:0] hdr;
      int          nw;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        gen;
      logic        gap;
      logic [31:0] csum;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input vec_t v, input int i);
      if (v.gen) return 32'hC0DE_0000 | 32'(i);
      return (i == 0) ? v.w0 : v.w1;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic gap);
      int t;
      if (gap) begin
         bus.in_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            last_acc = cyc;
            break;
         end
         t++;
         if (t > 20) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte 0x%02h not accepted, required within 20 cycles", b);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic send_word(input logic [31:0] w, input logic gap);
      send_byte(w[7:0], gap);
      send_byte(w[15:8], gap);
      send_byte(w[23:16], gap);
      send_byte(w[31:24], gap);
   endtask

   task automatic pulse_load;
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      wr_addr.delete();
      wr_data.delete();
      done_cyc = -1;
      we_while_run = 0;
      @(negedge clk);
      check("restart_core_rst", core_rst, 1);
      check("restart_done", done, 0);
      check("restart_ready", bus.in_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input vec_t v, input int n);
      pulse_load();
      send_word(v.hdr, v.gap);
      for (int i = 0; i < v.nw; i++) send_word(word_of(v, i), v.gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (v.hdr == 32'(v.nw)) send_word(v.csum, v.gap);
`endif
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_wr_count", n), wr_addr.size(), v.nw);
      for (int i = 0; i < v.nw && i < wr_addr.size(); i++) begin
         check($sformatf("v%0d_addr%0d", n, i), 32'(wr_addr[i]), i);
         check($sformatf("v%0d_data%0d", n, i), wr_data[i], word_of(v, i));
      end
      check($sformatf("v%0d_done", n), done, !v.exp_err);
      check($sformatf("v%0d_error", n), error, v.exp_err);
      check($sformatf("v%0d_core_rst", n), core_rst, v.exp_err);
      check($sformatf("v%0d_in_ready", n), bus.in_ready, 0);
      check($sformatf("v%0d_we_after_release", n), we_while_run, 0);
      if (!v.exp_err) check($sformatf("v%0d_done_timing", n), done_cyc, last_acc + 2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      logic [31:0] x;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;

      // Vector table
      vecs.push_back('{32'd2, 2, 32'h8C01_0000, 32'h0022_1820, 1'b0, 1'b0, 32'h8C23_1820, 1'b0});
      vecs.push_back('{32'd2, 2, 32'h8C01_0000, 32'h0022_1820, 1'b0, 1'b1, 32'h8C23_1820, 1'b0});
      vecs.push_back('{32'h0000_0101, 0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{32'd1, 1, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b0});
      vecs.push_back('{32'd0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0});
      x = '0;
      for (int i = 0; i < 256; i++) x = x ^ (32'hC0DE_0000 | 32'(i));
      vecs.push_back('{32'd256, 256, 32'h0, 32'h0, 1'b1, 1'b0, x, 1'b0});
      vecs.push_back('{32'hFFFF_FFFF, 0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1});
`ifdef IMEM_LOADER_CHECKSUM_EN
      vecs.push_back('{32'd2, 2, 32'h8C01_0000, 32'h0022_1820, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
`endif
      vecs.push_back('{32'd2, 2, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 32'hD500_4EE2, 1'b0});

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_core_rst", core_rst, 1);
      check("rst_we", bus.imem_we, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_waddr", 32'(bus.imem_waddr), 0);
      check("rst_wdata", bus.imem_wdata, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Restart after 5 data bytes, then reload a one-word image
      pulse_load();
      send_word(32'd2, 1'b0);
      send_word(32'h8C01_0000, 1'b0);
      send_byte(8'h20, 1'b0);
      bus.in_data  = 8'h18;
      bus.in_valid = 1'b1;
      load_req     = 1'b1;
      @(negedge clk);
      check("abort_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      load_req     = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("abort_core_rst", core_rst, 1);
      check("abort_done", done, 0);
      check("abort_hdr_ready", bus.in_ready, 1);
      check("abort_wr_count", wr_addr.size(), 1);
      wr_addr.delete();
      wr_data.delete();
      @(posedge clk); #1;
      send_word(32'd1, 1'b0);
      send_word(32'h1234_5678, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(32'h1234_5678, 1'b0);
`endif
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("reload_wr_count", wr_addr.size(), 1);
      if (wr_addr.size() > 0) begin
         check("reload_addr", 32'(wr_addr[0]), 0);
         check("reload_data", wr_data[0], 32'h1234_5678);
      end
      check("reload_done", done, 1);
      check("reload_core_rst", core_rst, 0);

      // Asynchronous reset takes effect without a clock edge
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("async_rst_done", done, 0);
      check("async_rst_core_rst", core_rst, 1);
      check("async_rst_ready", bus.in_ready, 1);
      #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
